mixer_seq: RTL and testbench
============================

// Module: mixer_seq
// PURPOSE
//  Bus initiator that drives the mixer control register interface (valid/address/wdata/wstrb/ready).
//  Executes fixed power-up / power-down write sequences with programmable settle delays between steps.
//  Sits between the radio control FSM and the mixer register block, replacing per-register CPU writes.
// PARAMETERS
//  ADDR_W     2     width of m_address
//  DATA_W     32    width of m_wdata
//  ADDR_PD    0     address of pd register
//  ADDR_OTA   1     address of ota register
//  ADDR_BUFF  2     address of buff register
//  T_PD       16    settle cycles after the pd write (>=1)
//  T_OTA      16    settle cycles after the ota write (>=1)
//  TIMEOUT    8     max cycles m_valid held without m_ready before abort (>=2)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset
//  cmd_up     in   1       1-cycle pulse: run power-up sequence
//  cmd_down   in   1       1-cycle pulse: run power-down sequence
//  buff_cfg   in   2       buff code; sampled on accepted cmd_up
//  busy       out  1       sequence in progress
//  done       out  1       1-cycle pulse: sequence completed
//  err        out  1       1-cycle pulse: write timed out, sequence aborted
//  is_on      out  1       1 after a completed up sequence, 0 after a completed down
//  m_valid    out  1       write request to mixer register block
//  m_address  out  ADDR_W  register address
//  m_wdata    out  DATA_W  write data, bits above [1:0] always 0
//  m_wstrb    out  1       always 1 while m_valid=1, else 0
//  m_ready    in   1       write accepted (registered in the target, >=1 cycle after m_valid)
// BEHAVIOUR
//  Reset: rst is asynchronous, active-high; clock clk. All outputs 0, FSM IDLE, counters 0.
//  Up sequence:   (ADDR_PD,0) -> settle T_PD -> (ADDR_OTA,1) -> settle T_OTA -> (ADDR_BUFF,buff_cfg).
//  Down sequence: (ADDR_BUFF,0) -> (ADDR_OTA,0) -> (ADDR_PD,1); no settle between down steps.
//  FSM: IDLE -> REQ -> WAIT -> (SETTLE) -> REQ ... -> FIN -> IDLE; ABORT -> IDLE on timeout.
//   IDLE: cmd accepted -> latch direction + buff_cfg, step=0, busy=1 next cycle.
//   REQ: m_valid=1 with address/wdata of current step; go WAIT same edge.
//   WAIT: hold m_valid/address/wdata stable until m_ready=1; on ready drop m_valid next cycle.
//   SETTLE: counter loads T-1, decrements to 0, m_valid=0 throughout; then REQ of next step.
//   FIN: done=1 one cycle, is_on updated same cycle, busy=0 next cycle.
//  Handshake: m_valid low for >=1 cycle between writes; m_ready while m_valid=0 ignored.
//  Latency: cmd_up to done = 3 writes + T_PD + T_OTA + fixed FSM overhead; exact count per bench.
//  Timeout: counter runs while m_valid=1; reaching TIMEOUT without m_ready -> m_valid=0, err=1 one
//   cycle, IDLE; is_on unchanged; remaining steps skipped.
//  cmd_up and cmd_down same cycle in IDLE: cmd_down wins. Commands while busy=1: ignored, not queued.
//  cmd_up while is_on=1 (or down while 0): executed anyway (re-programs buff).
//  Reset mid-sequence: immediate return to reset state; m_valid drops asynchronously.
//  done and err never both asserted; busy=0 in the cycle after either pulse.
// STRUCTURE
//  Shared header mixer_seq.vh: FSM state encodings, step indices, DIR_UP/DIR_DOWN.
//  Register addresses stay parameters so the block tracks the mixer address map.
//  Sub-module mixer_seq_wr: single-write engine (REQ/WAIT/timeout), start/addr/data in,
//   ok/timeout pulses out; mixer_seq holds sequence table, settle counter and status outputs.
// TESTING
//  Bench target: mixer register block plus a ready-stall injector.
//  cmd_up, buff_cfg=2'b10, ready 1 cycle after valid -> writes (0,0),(1,1),(2,2) in order;
//   gap >= T_PD between write 1 ready and write 2 valid, >= T_OTA before write 3;
//   done pulse; is_on=1; mixer pd=0 ota=1 buff=2.
//  cmd_down after up -> writes (2,0),(1,0),(0,1); done; is_on=0; mixer buff=0 ota=0 pd=1.
//  Ready stalled 5 cycles on write 2 (TIMEOUT=8) -> m_valid/address/wdata stable all 5 cycles; completes.
//  Ready never returned on write 2 -> m_valid high exactly TIMEOUT cycles; err pulse; no write 3; is_on=0.
//  cmd_up and cmd_down same cycle from IDLE -> down sequence; cmd_up pulse while busy -> ignored.
//  rst asserted during SETTLE of up -> outputs 0 immediately; post-reset cmd_up runs full sequence.

Source files
------------

// File: rtl/mixer_seq_pkg.sv
// Shared types for the mixer power sequencer: FSM states, sequence directions,
// step indices and the fixed up/down write table.
package mixer_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SETTLE,
    S_FIN,
    S_ABORT
  } seq_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT
  } wr_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    REG_PD,
    REG_OTA,
    REG_BUFF
  } reg_sel_e;

  typedef logic [1:0] step_t;

  localparam step_t STEP_FIRST  = 2'd0;
  localparam step_t STEP_SECOND = 2'd1;
  localparam step_t STEP_LAST   = 2'd2;

  typedef struct packed {
    reg_sel_e   sel;
    logic [1:0] code;
  } seq_entry_t;

  // Register and data code written at a given step; addresses are resolved by the top.
  function automatic seq_entry_t seq_lookup(input dir_e dir, input step_t step,
                                            input logic [1:0] buff);
    seq_entry_t e;
    e = '{REG_PD, 2'd0};
    if (dir == DIR_UP) begin
      case (step)
        STEP_FIRST:  e = '{REG_PD, 2'd0};
        STEP_SECOND: e = '{REG_OTA, 2'd1};
        default:     e = '{REG_BUFF, buff};
      endcase
    end else begin
      case (step)
        STEP_FIRST:  e = '{REG_BUFF, 2'd0};
        STEP_SECOND: e = '{REG_OTA, 2'd0};
        default:     e = '{REG_PD, 2'd1};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/mixer_seq_if.sv
// Write-only register bus between the sequencer (master) and the mixer register block (slave).
interface mixer_seq_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);

  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              wstrb;
  logic              ready;

  modport master (
    output valid,
    output address,
    output wdata,
    output wstrb,
    input  ready
  );

  modport slave (
    input  valid,
    input  address,
    input  wdata,
    input  wstrb,
    output ready
  );

endinterface

// File: rtl/mixer_seq_wr.sv
// Single-write engine: issues one bus write on start, holds it until ready,
// and gives up after TIMEOUT cycles of valid without ready.
module mixer_seq_wr
  import mixer_seq_pkg::*;
#(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        data,
  output logic              ok,
  output logic              timeout,
  mixer_seq_if.master       m
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  wr_state_e        state;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of cycles valid has been high, including the current one.
  // The target registers ready, so it cannot answer in the first valid cycle (REQ).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= W_IDLE;
      cnt       <= '0;
      ok        <= 1'b0;
      timeout   <= 1'b0;
      m.valid   <= 1'b0;
      m.address <= '0;
      m.wdata   <= '0;
      m.wstrb   <= 1'b0;
    end else begin
      ok      <= 1'b0;
      timeout <= 1'b0;
      case (state)
        W_IDLE: begin
          if (start) begin
            m.valid   <= 1'b1;
            m.wstrb   <= 1'b1;
            m.address <= addr;
            m.wdata   <= DATA_W'(data);
            cnt       <= CNT_W'(1);
            state     <= W_REQ;
          end
        end
        W_REQ: begin
          cnt   <= cnt + 1'b1;
          state <= W_WAIT;
        end
        W_WAIT: begin
          if (m.ready) begin
            m.valid <= 1'b0;
            m.wstrb <= 1'b0;
            ok      <= 1'b1;
            cnt     <= '0;
            state   <= W_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            m.valid <= 1'b0;
            m.wstrb <= 1'b0;
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= W_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mixer_seq.sv
// Mixer power sequencer: walks the fixed up/down write tables through the
// write engine, inserting settle delays and reporting done/err/is_on.
module mixer_seq
  import mixer_seq_pkg::*;
#(
  parameter int              ADDR_W    = 2,
  parameter int              DATA_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_PD   = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] ADDR_OTA  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] ADDR_BUFF = ADDR_W'(2),
  parameter int              T_PD      = 16,
  parameter int              T_OTA     = 16,
  parameter int              TIMEOUT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_up,
  input  logic        cmd_down,
  input  logic [1:0]  buff_cfg,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        is_on,
  mixer_seq_if.master m
);

  localparam int T_MAX    = (T_PD > T_OTA) ? T_PD : T_OTA;
  localparam int SETTLE_W = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;
  localparam logic [SETTLE_W-1:0] PD_LOAD  = SETTLE_W'(T_PD - 1);
  localparam logic [SETTLE_W-1:0] OTA_LOAD = SETTLE_W'(T_OTA - 1);

  seq_state_e          state;
  dir_e                dir;
  logic [1:0]          buff;
  step_t               step;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                start;
  logic                wr_ok;
  logic                wr_timeout;
  seq_entry_t          entry;
  logic [ADDR_W-1:0]   step_addr;

  assign entry = seq_lookup(dir, step, buff);

  always_comb begin
    step_addr = ADDR_PD;
    case (entry.sel)
      REG_OTA:  step_addr = ADDR_OTA;
      REG_BUFF: step_addr = ADDR_BUFF;
      default:  step_addr = ADDR_PD;
    endcase
  end

  mixer_seq_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) u_wr (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .addr   (step_addr),
    .data   (entry.code),
    .ok     (wr_ok),
    .timeout(wr_timeout),
    .m      (m)
  );

  // start is raised together with the step/dir update so the engine latches the new table entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dir        <= DIR_UP;
      buff       <= 2'd0;
      step       <= STEP_FIRST;
      settle_cnt <= '0;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      is_on      <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_up || cmd_down) begin
            dir   <= cmd_down ? DIR_DOWN : DIR_UP;
            if (!cmd_down) buff <= buff_cfg;
            step  <= STEP_FIRST;
            start <= 1'b1;
            busy  <= 1'b1;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_timeout) begin
            err   <= 1'b1;
            state <= S_ABORT;
          end else if (wr_ok) begin
            if (step == STEP_LAST) begin
              done  <= 1'b1;
              is_on <= (dir == DIR_UP);
              state <= S_FIN;
            end else begin
              step <= step + 2'd1;
              if (dir == DIR_UP) begin
                settle_cnt <= (step == STEP_FIRST) ? PD_LOAD : OTA_LOAD;
                state      <= S_SETTLE;
              end else begin
                start <= 1'b1;
              end
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            start <= 1'b1;
            state <= S_WRITE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_FIN, S_ABORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_seq.sv
// Bench for mixer_seq: a mixer register block with ready-stall injection answers the bus,
// and a table-level model of the up/down sequences supplies the expected writes and status.
module tb_mixer_seq;

  localparam int ADDR_W  = 2;
  localparam int DATA_W  = 32;
  localparam int T_PD    = 16;
  localparam int T_OTA   = 16;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_up = 1'b0;
  logic       cmd_down = 1'b0;
  logic [1:0] buff_cfg = 2'd0;
  logic       busy, done, err, is_on;

  mixer_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

  mixer_seq #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ADDR_PD(2'd0), .ADDR_OTA(2'd1), .ADDR_BUFF(2'd2),
    .T_PD(T_PD), .T_OTA(T_OTA), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .cmd_up(cmd_up), .cmd_down(cmd_down), .buff_cfg(buff_cfg),
    .busy(busy), .done(done), .err(err), .is_on(is_on), .m(m)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // register block / monitor state
  int  cyc = 0;
  int  vcycles = 0;
  int  cur_lat = 1;
  int  last_accept_cyc = -1;
  int  wr_idx = 0;
  int  fixed_lat = 0;
  int  stall_idx = -1;
  int  stall_lat = 1;
  bit  never_ready = 1'b0;
  int  never_idx = -1;
  bit  spurious_en = 1'b0;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] mirror [3] = '{default: '0};
  wr_t wr_log [$];
  int  gaps [$];
  int  runs [$];
  int  valid_rises = 0;
  int  stable_fail = 0;
  int  done_cnt = 0;
  int  err_cnt = 0;
  int  both_cnt = 0;
  int  busy_fail = 0;
  bit  prev_pulse = 1'b0;

  // reference model state
  wr_t exp_q [$];
  bit  exp_up;
  bit  model_is_on = 1'b0;
  logic [DATA_W-1:0] model_regs [3] = '{default: '0};

  function automatic wr_t mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  function automatic int gapAt(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  function automatic int runAt(input int i);
    return (i < runs.size()) ? runs[i] : -1;
  endfunction

  // Mixer register block: ready registered cur_lat cycles after valid, optional stray ready pulses.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m.ready = 1'b0;
      vcycles = 0;
      prev_pulse = 1'b0;
      last_accept_cyc = -1;
    end else begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
      if (prev_pulse && busy) busy_fail++;
      prev_pulse = done | err;
      if (!m.valid && m.wstrb) stable_fail++;
      if (m.ready) m.ready = 1'b0;
      if (m.valid) begin
        vcycles++;
        if (m.wstrb !== 1'b1) stable_fail++;
        if (vcycles == 1) begin
          valid_rises++;
          cap_addr = m.address;
          cap_data = m.wdata;
          if (last_accept_cyc >= 0) gaps.push_back(cyc - last_accept_cyc - 1);
          if (never_ready && wr_idx == never_idx) cur_lat = 100000;
          else if (wr_idx == stall_idx) cur_lat = stall_lat;
          else if (fixed_lat > 0) cur_lat = fixed_lat;
          else cur_lat = $urandom_range(1, 3);
        end else if (m.address !== cap_addr || m.wdata !== cap_data) begin
          stable_fail++;
        end
        if (vcycles == cur_lat + 1) begin
          m.ready = 1'b1;
          wr_log.push_back(mk(m.address, m.wdata));
          if (m.address < 2'd3) mirror[m.address] = m.wdata;
          last_accept_cyc = cyc;
          wr_idx++;
        end
      end else begin
        if (vcycles > 0) runs.push_back(vcycles);
        vcycles = 0;
        if (spurious_en && $urandom_range(0, 3) == 0) m.ready = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit up, input bit down, input logic [1:0] b);
    cmd_up = up;
    cmd_down = down;
    buff_cfg = b;
    tick(1);
    cmd_up = 1'b0;
    cmd_down = 1'b0;
    buff_cfg = 2'($urandom);
  endtask

  // Down wins when both commands arrive together.
  task automatic startSeq(input bit up, input bit down, input logic [1:0] b);
    done_cnt = 0; err_cnt = 0; valid_rises = 0; stable_fail = 0; wr_idx = 0;
    last_accept_cyc = -1;
    wr_log.delete(); gaps.delete(); runs.delete(); exp_q.delete();
    exp_up = up && !down;
    if (exp_up) begin
      exp_q.push_back(mk(2'd0, 32'd0));
      exp_q.push_back(mk(2'd1, 32'd1));
      exp_q.push_back(mk(2'd2, {30'd0, b}));
    end else begin
      exp_q.push_back(mk(2'd2, 32'd0));
      exp_q.push_back(mk(2'd1, 32'd0));
      exp_q.push_back(mk(2'd0, 32'd1));
    end
    applyStimulus(up, down, b);
  endtask

  task automatic waitEnd(input string tag);
    int n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 600) begin
      tick(1);
      n++;
    end
    if (done_cnt == 0 && err_cnt == 0) checkOutput({tag, "_ended"}, 32'd0, 32'd1);
  endtask

  task automatic finishSeq(input string tag);
    waitEnd(tag);
    tick(8);
    checkOutput({tag, "_done_cycles"}, done_cnt, 1);
    checkOutput({tag, "_err_cycles"}, err_cnt, 0);
    checkOutput({tag, "_writes"}, wr_log.size(), 3);
    checkOutput({tag, "_valid_rises"}, valid_rises, 3);
    for (int i = 0; i < 3; i++) begin
      wr_t got = (i < wr_log.size()) ? wr_log[i] : mk(2'd3, '1);
      checkOutput($sformatf("%s_w%0d_addr", tag, i), 32'(got.a), 32'(exp_q[i].a));
      checkOutput($sformatf("%s_w%0d_data", tag, i), got.d, exp_q[i].d);
      model_regs[exp_q[i].a] = exp_q[i].d;
    end
    if (exp_up) begin
      checkOutput({tag, "_gap_pd"}, 32'(gapAt(0) >= T_PD), 32'd1);
      checkOutput({tag, "_gap_ota"}, 32'(gapAt(1) >= T_OTA), 32'd1);
    end else begin
      checkOutput({tag, "_gap_down"}, 32'(gapAt(0) >= 1 && gapAt(1) >= 1), 32'd1);
    end
    checkOutput({tag, "_stable"}, stable_fail, 0);
    model_is_on = exp_up;
    checkOutput({tag, "_is_on"}, 32'(is_on), 32'(model_is_on));
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("%s_reg%0d", tag, k), mirror[k], model_regs[k]);
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid_idle"}, 32'(m.valid), 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] b;
    bit up;

    #1;
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    checkOutput("rst_async_valid", 32'(m.valid), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(2);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_is_on", 32'(is_on), 32'd0);
    checkOutput("rst_wstrb", 32'(m.wstrb), 32'd0);
    checkOutput("rst_addr", 32'(m.address), 32'd0);
    checkOutput("rst_wdata", m.wdata, 32'd0);

    fixed_lat = 1;
    startSeq(1'b1, 1'b0, 2'b10);
    finishSeq("up");
    startSeq(1'b0, 1'b1, 2'b00);
    finishSeq("down");
    fixed_lat = 0;

    stall_idx = 1; stall_lat = 5;
    startSeq(1'b1, 1'b0, 2'($urandom));
    finishSeq("stall");
    checkOutput("stall_run_len", runAt(1), 6);
    stall_idx = -1;

    startSeq(1'b1, 1'b0, 2'b01);
    finishSeq("reup");

    // reset while the up sequence waits out the pd settle time
    startSeq(1'b1, 1'b0, 2'b11);
    n = 0;
    while (wr_log.size() < 1 && n < 100) begin tick(1); n++; end
    tick(3);
    checkOutput("settle_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("settle_rst_busy", 32'(busy), 32'd0);
    checkOutput("settle_rst_is_on", 32'(is_on), 32'd0);
    checkOutput("settle_rst_valid", 32'(m.valid), 32'd0);
    model_regs[exp_q[0].a] = exp_q[0].d;
    model_is_on = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    startSeq(1'b1, 1'b0, 2'b11);
    finishSeq("post_rst_up");

    startSeq(1'b0, 1'b1, 2'b00);
    finishSeq("pre_to_down");
    never_ready = 1'b1; never_idx = 1;
    startSeq(1'b1, 1'b0, 2'b10);
    waitEnd("to");
    tick(20);
    checkOutput("to_err_cycles", err_cnt, 1);
    checkOutput("to_done_cycles", done_cnt, 0);
    checkOutput("to_valid_len", runAt(1), TIMEOUT);
    checkOutput("to_valid_rises", valid_rises, 2);
    checkOutput("to_writes", wr_log.size(), 1);
    checkOutput("to_is_on", 32'(is_on), 32'(model_is_on));
    checkOutput("to_busy", 32'(busy), 32'd0);
    model_regs[exp_q[0].a] = exp_q[0].d;
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("to_reg%0d", k), mirror[k], model_regs[k]);
    never_ready = 1'b0; never_idx = -1;

    startSeq(1'b1, 1'b1, 2'b11);
    tick(4);
    checkOutput("both_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'b01);
    finishSeq("both");

    // reset while a write is on the bus
    stall_idx = 0; stall_lat = 6;
    startSeq(1'b0, 1'b1, 2'b00);
    n = 0;
    while (m.valid !== 1'b1 && n < 50) begin tick(1); n++; end
    checkOutput("vrst_valid_seen", 32'(m.valid), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("vrst_valid", 32'(m.valid), 32'd0);
    checkOutput("vrst_wstrb", 32'(m.wstrb), 32'd0);
    checkOutput("vrst_busy", 32'(busy), 32'd0);
    model_is_on = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    stall_idx = -1;

    spurious_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up = 1'($urandom);
      b = 2'($urandom);
      startSeq(up, !up, b);
      finishSeq($sformatf("rnd%0d", i));
    end

    checkOutput("done_err_overlap", both_cnt, 0);
    checkOutput("busy_after_pulse", busy_fail, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
